// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared sweep-state encoding, queue sizing and pack-index helpers
package tpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sweep_state_e;

    // Address driven on a bank that is not being written this cycle.
    localparam int ADDR_IDLE = 127;

    function automatic int queue_count(input int array_size);
        return (array_size + 3) / 4;
    endfunction

    // MSB position of queue k's slice inside a packed per-queue bus.
    function automatic int pack_msb(input int k, input int width);
        return (k + 1) * width - 1;
    endfunction

endpackage

// File: rtl/wr_window.sv
// rtl/wr_window.sv - maps the sweep counter onto one queue's write enable and row address
module wr_window
    import tpu_pkg::*;
#(
    parameter int LO             = 8,
    parameter int ROW_COUNT      = 99,
    parameter int CNT_W          = 7,
    parameter int ADDR_WIDTH     = 10,
    parameter int ADDR_WIDTH_MIN = 7
) (
    input  logic                  en,
    input  logic [CNT_W-1:0]      cnt,
    output logic                  wen_nx,
    output logic [ADDR_WIDTH-1:0] addr_nx
);

    localparam int HI = LO + ROW_COUNT - 1;

    int                        cnt_i;
    logic [ADDR_WIDTH_MIN-1:0] row;

    always_comb begin
        cnt_i   = int'(cnt);
        row     = ADDR_WIDTH_MIN'(cnt_i - LO);
        wen_nx  = 1'b0;
        addr_nx = ADDR_WIDTH'(ADDR_IDLE);
        if (en && (cnt_i >= LO) && (cnt_i <= HI)) begin
            wen_nx  = 1'b1;
            addr_nx = ADDR_WIDTH'(row);
        end
    end

endmodule

// File: rtl/result_wr_sel.sv
// rtl/result_wr_sel.sv - skewed result-SRAM write address/enable sweep; optional stall via RESULT_WR_STALL_EN
module result_wr_sel
    import tpu_pkg::*;
#(
    parameter int ARRAY_SIZE     = 8,
    parameter int QUEUE_COUNT    = queue_count(ARRAY_SIZE),
    parameter int QUEUE_SIZE     = 4,
    parameter int ROW_COUNT      = 99,
    parameter int PIPE_LAT       = ARRAY_SIZE,
    parameter int ADDR_WIDTH     = 10,
    parameter int ADDR_WIDTH_MIN = 7
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic [QUEUE_COUNT*ADDR_WIDTH-1:0] sram_waddr_packed,
    output logic [QUEUE_COUNT-1:0]            sram_wen_packed
`ifdef RESULT_WR_STALL_EN
    ,
    input  logic                              hold
`endif
);

    localparam int CNT_LAST = (QUEUE_COUNT - 1) * QUEUE_SIZE + PIPE_LAT + ROW_COUNT - 1;
    localparam int CNT_W    = $clog2(CNT_LAST + 1);

    localparam logic [QUEUE_COUNT*ADDR_WIDTH-1:0] ADDR_IDLE_ALL =
        {QUEUE_COUNT{ADDR_WIDTH'(ADDR_IDLE)}};

    sweep_state_e state_q, state_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             run;
    logic             stall;

    logic [QUEUE_COUNT*ADDR_WIDTH-1:0] waddr_nx;
    logic [QUEUE_COUNT-1:0]            wen_nx;

`ifdef RESULT_WR_STALL_EN
    assign stall = hold;
`else
    assign stall = 1'b0;
`endif

    assign run  = (state_q == ST_RUN);
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_RUN;
                    cnt_nx   = '0;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (cnt_q == CNT_W'(CNT_LAST)) begin
                        state_nx = ST_DONE;
                    end else begin
                        cnt_nx = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Each queue's window trails the previous one by QUEUE_SIZE cycles.
    for (genvar k = 0; k < QUEUE_COUNT; k++) begin : g_queue
        wr_window #(
            .LO             (PIPE_LAT + k * QUEUE_SIZE),
            .ROW_COUNT      (ROW_COUNT),
            .CNT_W          (CNT_W),
            .ADDR_WIDTH     (ADDR_WIDTH),
            .ADDR_WIDTH_MIN (ADDR_WIDTH_MIN)
        ) u_win (
            .en      (run),
            .cnt     (cnt_q),
            .wen_nx  (wen_nx[k]),
            .addr_nx (waddr_nx[pack_msb(k, ADDR_WIDTH) -: ADDR_WIDTH])
        );
    end

    // A stalled cycle suppresses the write but keeps the last address on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_wen_packed   <= '0;
            sram_waddr_packed <= ADDR_IDLE_ALL;
        end else if (run && stall) begin
            sram_wen_packed   <= '0;
        end else begin
            sram_wen_packed   <= wen_nx;
            sram_waddr_packed <= waddr_nx;
        end
    end

endmodule
